// File: rtl/multdiv_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_shift_register
// Purpose  : Parametrised working register for the multiply/divide unit.
//            Supports parallel load, logical shift-left with a serial bit
//            inserted at the LSB (restoring division) and arithmetic
//            shift-right (Booth multiplication). An internal step counter
//            tracks the shifts of the current operation and raises a sticky
//            done flag after STEPS shifts.
// Ports    : clk     - rising-edge clock
//            clr_n   - asynchronous active-low clear
//            start   - load `in`, clear counter, enter RUN (overrides mode)
//            w_en    - enables the mode operation
//            mode    - 00 hold, 01 load, 10 shift-left, 11 arith shift-right
//            in      - parallel load data
//            ser_in  - bit inserted at LSB on shift-left
//            r_en    - drives `out` onto the shared result bus
//            out     - register contents when r_en=1, otherwise high-Z
//            ser_out - bit the current mode shifts out (combinational)
//            count   - shifts completed in the current operation
//            busy    - operation in progress
//            done    - sticky completion flag
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_shift_register #(
  parameter int WIDTH = 64,
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             w_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             ser_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_ASR  = 2'b11;

  // Counter value just before the final shift of an operation.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_en;

  always_comb begin
    reg_d    = reg_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    shift_en = 1'b0;

    if (start) begin
      reg_d   = in;
      count_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (w_en) begin
      case (mode)
        MODE_HOLD: reg_d = reg_q;
        MODE_LOAD: reg_d = in;
        MODE_SHL: begin
          reg_d    = {reg_q[WIDTH-2:0], ser_in};
          shift_en = 1'b1;
        end
        MODE_ASR: begin
          reg_d    = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        default: reg_d = reg_q;
      endcase

      // Only shifts inside a running operation are counted; once the
      // operation completes busy drops, so the counter can never wrap.
      if (shift_en && busy_q) begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reg_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ser_out follows the mode selection alone, so the datapath can sample the
  // outgoing bit before deciding to commit the shift.
  always_comb begin
    ser_out = 1'b0;
    case (mode)
      MODE_SHL: ser_out = reg_q[WIDTH-1];
      MODE_ASR: ser_out = reg_q[0];
      default:  ser_out = 1'b0;
    endcase
  end

  assign out   = r_en ? reg_q : {WIDTH{1'bz}};
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_shift_register
// Purpose  : Self-checking bench for multdiv_shift_register. A driver issues
//            directed and random operations, predicts the response with a
//            behavioural model and queues it; a monitor compares the DUT
//            after every clock edge. The bench also drives the shared result
//            bus whenever the DUT releases it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_shift_register;

  localparam int WIDTH = 64;
  localparam int STEPS = 32;
  localparam int CNT_W = 6;

  logic             clk;
  logic             clr_n;
  logic             start;
  logic             w_en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] din;
  logic             ser_in;
  logic             r_en;
  logic [WIDTH-1:0] alt;
  wire  [WIDTH-1:0] bus;
  logic             ser_out;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  // Second bus talker: drives only while the DUT has released the bus.
  assign bus = r_en ? {WIDTH{1'bz}} : alt;

  multdiv_shift_register #(.WIDTH(WIDTH), .STEPS(STEPS), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .w_en   (w_en),
    .mode   (mode),
    .in     (din),
    .ser_in (ser_in),
    .r_en   (r_en),
    .out    (bus),
    .ser_out(ser_out),
    .count  (count),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] bus;
    int               count;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];

  // Behavioural model state
  logic [WIDTH-1:0] m_reg;
  int               m_count;
  logic             m_busy;
  logic             m_done;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_reg   = '0;
    m_count = 0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clocked operation: drive at the falling edge, check ser_out, predict
  // the post-edge state and hand it to the monitor.
  task automatic op(input logic st, input logic we, input logic [1:0] md,
                    input logic [WIDTH-1:0] d, input logic si, input logic re,
                    input logic [WIDTH-1:0] a);
    exp_t e;
    logic exp_so;
    @(negedge clk);
    start = st; w_en = we; mode = md; din = d; ser_in = si; r_en = re; alt = a;
    #1;
    exp_so = (md == 2'd2) ? m_reg[WIDTH-1] : (md == 2'd3) ? m_reg[0] : 1'b0;
    chk("ser_out", {{(WIDTH-1){1'b0}}, ser_out}, {{(WIDTH-1){1'b0}}, exp_so});
    if (st) begin
      m_reg = d; m_count = 0; m_busy = 1'b1; m_done = 1'b0;
    end else if (we && md != 2'd0) begin
      if (md == 2'd1) m_reg = d;
      else if (md == 2'd2) m_reg = (m_reg * 2) + WIDTH'(si);
      else m_reg = $unsigned($signed(m_reg) >>> 1);
      if (md[1] && m_busy) begin
        m_count = m_count + 1;
        if (m_count == STEPS) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    e.bus   = re ? m_reg : a;
    e.count = m_count;
    e.busy  = m_busy;
    e.done  = m_done;
    q.push_back(e);
  endtask

  task automatic shl(input logic si);
    op(1'b0, 1'b1, 2'd2, '0, si, 1'b1, '0);
  endtask

  // Directed check of state after the edge that follows the last op().
  task automatic post(input string name, input int c, input logic b, input logic dn);
    @(posedge clk);
    #2;
    chk({name, "_count"}, WIDTH'(count), WIDTH'(c));
    chk({name, "_busy"},  WIDTH'(busy),  WIDTH'(b));
    chk({name, "_done"},  WIDTH'(done),  WIDTH'(dn));
  endtask

  // Monitor: compares every queued prediction one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_bus",   bus,            e.bus);
        chk("sb_count", WIDTH'(count),  WIDTH'(e.count));
        chk("sb_busy",  WIDTH'(busy),   WIDTH'(e.busy));
        chk("sb_done",  WIDTH'(done),   WIDTH'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with no clock edge yet (first rising edge is at t=5).
    start = 0; w_en = 0; mode = 0; din = '0; ser_in = 0; r_en = 1;
    alt = 64'hA5A5_5A5A_DEAD_BEEF;
    clr_n = 0;
    model_reset();
    #1;
    chk("rst_out",   bus, '0);
    chk("rst_count", WIDTH'(count), '0);
    chk("rst_busy",  WIDTH'(busy),  '0);
    chk("rst_done",  WIDTH'(done),  '0);
    r_en = 0;
    #1;
    chk("rst_bus_released", bus, 64'hA5A5_5A5A_DEAD_BEEF);
    r_en = 1;
    #1;
    clr_n = 1;

    // Load, then hold with w_en=0 while mode requests a shift.
    op(0, 1, 2'd1, 64'h0123_4567_89AB_CDEF, 0, 1, '0);
    @(posedge clk); #2;
    chk("load", bus, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) op(0, 0, 2'd2, '0, 1, 1, '0);
    @(posedge clk); #2;
    chk("hold", bus, 64'h0123_4567_89AB_CDEF);

    // Shift-left with serial insert.
    op(1, 0, 2'd0, 64'h8000_0000_0000_0001, 0, 1, '0);
    shl(1'b1);
    @(posedge clk); #2;
    chk("shl_out", bus, 64'h0000_0000_0000_0003);
    chk("shl_count", WIDTH'(count), 64'd1);

    // Arithmetic shift-right.
    op(1, 0, 2'd0, 64'hF000_0000_0000_0002, 0, 1, '0);
    op(0, 1, 2'd3, '0, 0, 1, '0);
    @(posedge clk); #2;
    chk("asr_out", bus, 64'hF800_0000_0000_0001);

    // Completion with a load edge and an idle edge in between.
    op(1, 0, 2'd0, 64'h1357_9BDF_0246_8ACE, 0, 1, '0);
    for (int i = 0; i < 31; i++) begin
      if (i == 10) op(0, 1, 2'd1, 64'hFFFF_0000_FFFF_0000, 0, 1, '0);
      if (i == 20) op(0, 0, 2'd3, '0, 0, 0, 64'h1111_2222_3333_4444);
      op(0, 1, (i % 2 == 0) ? 2'd2 : 2'd3, '0, i[0], 1, '0);
    end
    post("shift31", 31, 1'b1, 1'b0);
    shl(1'b0);
    post("shift32", 32, 1'b0, 1'b1);
    shl(1'b1);
    post("shift33", 32, 1'b0, 1'b1);

    // Restart mid-operation, then async reset mid-operation.
    op(1, 0, 2'd0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1, '0);
    for (int i = 0; i < 10; i++) shl(1'b1);
    op(1, 1, 2'd2, 64'hCAFE_BABE_1234_5678, 1, 1, '0);
    post("restart", 0, 1'b1, 1'b0);
    chk("restart_reg", bus, 64'hCAFE_BABE_1234_5678);
    for (int i = 0; i < 5; i++) shl(1'b0);
    @(negedge clk);
    start = 0; w_en = 0; mode = 2'd2;
    clr_n = 0;
    model_reset();
    #1;
    chk("midrst_out", bus, '0);
    chk("midrst_count", WIDTH'(count), '0);
    chk("midrst_busy", WIDTH'(busy), '0);
    clr_n = 1;
    for (int i = 0; i < 3; i++) shl(1'b1);
    post("after_rst", 0, 1'b0, 1'b0);

    // Random traffic checked by the model through the scoreboard.
    for (int i = 0; i < 400; i++) begin
      op(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
         2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom),
         ($urandom_range(0, 1) == 1), {$urandom, $urandom});
    end

    @(posedge clk); #3;
    chk("queue_drained", WIDTH'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
